// File: rtl/micro_op_sequencer.sv
// Buffers one decode group of micro-ops, compacts them into program order and
// feeds rename up to DECODE_WIDTH ops per cycle while enforcing serialization.
module micro_op_sequencer #(
    parameter  int DECODE_WIDTH     = 2,
    parameter  int MICRO_OP_MAX_NUM = 3,
    parameter  int OP_INFO_WIDTH    = 96,
    localparam int ALL_SLOTS        = DECODE_WIDTH * MICRO_OP_MAX_NUM,
    localparam int HW               = $clog2(ALL_SLOTS),
    localparam int CW               = $clog2(ALL_SLOTS + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   flush,
    input  logic                                   inValid,
    output logic                                   inReady,
    input  logic [ALL_SLOTS-1:0]                   inMopValid,
    input  logic [ALL_SLOTS*OP_INFO_WIDTH-1:0]     inMopPayload,
    input  logic [DECODE_WIDTH-1:0]                inSerialized,
    input  logic                                   retireEmpty,
    output logic [DECODE_WIDTH-1:0]                outValid,
    output logic [DECODE_WIDTH*OP_INFO_WIDTH-1:0]  outPayload,
    input  logic                                   outReady,
    output logic                                   serialStall
);

    typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, SERIAL_WAIT = 2'd2} state_t;

    state_t                    state_r, state_next_s;
    logic [OP_INFO_WIDTH-1:0]  payload_r [ALL_SLOTS];
    logic [ALL_SLOTS-1:0]      ser_r;
    logic [HW-1:0]             head_r, head_next_s;
    logic [CW-1:0]             count_r, count_next_s;

    logic [OP_INFO_WIDTH-1:0]  comp_payload_s [ALL_SLOTS];
    logic [ALL_SLOTS-1:0]      comp_ser_s;
    logic [CW-1:0]             comp_count_s;
    logic [CW-1:0]             issued_s;
    logic                      blocked_s;
    logic [HW-1:0]             idx_s;
    logic                      accept_s;

    // Compact valid slots into program order (instruction 0 first, mop ascending)
    always_comb begin
        comp_count_s = {CW{1'b0}};
        comp_ser_s   = {ALL_SLOTS{1'b0}};
        for (int s = 0; s < ALL_SLOTS; s++) begin
            comp_payload_s[s] = {OP_INFO_WIDTH{1'b0}};
        end
        for (int s = 0; s < ALL_SLOTS; s++) begin
            if (inMopValid[s]) begin
                comp_payload_s[comp_count_s[HW-1:0]] = inMopPayload[s*OP_INFO_WIDTH +: OP_INFO_WIDTH];
                comp_ser_s[comp_count_s[HW-1:0]]     = inSerialized[s / MICRO_OP_MAX_NUM];
                comp_count_s                         = comp_count_s + CW'(1);
            end else begin
                comp_count_s = comp_count_s;
            end
        end
    end

    // Lane selection; a serialized entry stops every later lane this cycle
    always_comb begin
        outValid   = {DECODE_WIDTH{1'b0}};
        outPayload = {(DECODE_WIDTH*OP_INFO_WIDTH){1'b0}};
        issued_s   = {CW{1'b0}};
        blocked_s  = flush;
        idx_s      = head_r;
        for (int l = 0; l < DECODE_WIDTH; l++) begin
            idx_s = HW'(int'(head_r) + l);
            if (!blocked_s && (l < int'(count_r))) begin
                if (ser_r[idx_s]) begin
                    if ((l == 0) && retireEmpty) begin
                        outValid[l]                                    = 1'b1;
                        outPayload[l*OP_INFO_WIDTH +: OP_INFO_WIDTH]   = payload_r[idx_s];
                        issued_s                                       = issued_s + CW'(1);
                    end else begin
                        outValid[l] = 1'b0;
                    end
                    blocked_s = 1'b1;
                end else begin
                    outValid[l]                                  = 1'b1;
                    outPayload[l*OP_INFO_WIDTH +: OP_INFO_WIDTH] = payload_r[idx_s];
                    issued_s                                     = issued_s + CW'(1);
                end
            end else begin
                blocked_s = 1'b1;
            end
        end
    end

    // Handshake, stall flag and next head/count
    always_comb begin
        serialStall  = (count_r != {CW{1'b0}}) && ser_r[head_r] && !retireEmpty;
        inReady      = !flush && ((count_r == {CW{1'b0}}) || ((count_r == issued_s) && outReady));
        accept_s     = inValid && inReady;
        head_next_s  = head_r;
        count_next_s = count_r;
        if (flush) begin
            head_next_s  = {HW{1'b0}};
            count_next_s = {CW{1'b0}};
        end else if (accept_s) begin
            head_next_s  = {HW{1'b0}};
            count_next_s = comp_count_s;
        end else if (outReady && (issued_s != {CW{1'b0}})) begin
            head_next_s  = head_r + HW'(issued_s);
            count_next_s = count_r - issued_s;
        end else begin
            head_next_s  = head_r;
            count_next_s = count_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (count_next_s != {CW{1'b0}}) state_next_s = DRAIN;
                    else                            state_next_s = IDLE;
                end
                DRAIN: begin
                    if (count_next_s == {CW{1'b0}}) state_next_s = IDLE;
                    else if (serialStall)           state_next_s = SERIAL_WAIT;
                    else                            state_next_s = DRAIN;
                end
                SERIAL_WAIT: begin
                    if (retireEmpty) state_next_s = DRAIN;
                    else             state_next_s = SERIAL_WAIT;
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State, pointer and buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            head_r  <= {HW{1'b0}};
            count_r <= {CW{1'b0}};
            ser_r   <= {ALL_SLOTS{1'b0}};
            for (int s = 0; s < ALL_SLOTS; s++) begin
                payload_r[s] <= {OP_INFO_WIDTH{1'b0}};
            end
        end else begin
            state_r <= state_next_s;
            head_r  <= head_next_s;
            count_r <= count_next_s;
            if (accept_s && !flush) begin
                ser_r <= comp_ser_s;
                for (int s = 0; s < ALL_SLOTS; s++) begin
                    payload_r[s] <= comp_payload_s[s];
                end
            end else begin
                ser_r <= ser_r;
            end
        end
    end

endmodule
